// File: rtl/class_fifo_pkg.sv
// Shared definitions for the class demux, the per-class FIFOs and the downstream arbiter.
package class_fifo_pkg;

   localparam int unsigned DefWidth = 12;
   localparam int unsigned DefDepth = 8;
   localparam int unsigned ClassMsb = 11;
   localparam int unsigned ClassLsb = 10;

   typedef enum logic [1:0] {
      Class0 = 2'b00,
      Class1 = 2'b01,
      Class2 = 2'b10,
      Class3 = 2'b11
   } traffic_class_e;

   function automatic traffic_class_e get_class(input logic [DefWidth-1:0] word);
      return traffic_class_e'(word[ClassMsb:ClassLsb]);
   endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: one synchronous write port, one registered read port.
module fifo_mem
   import class_fifo_pkg::*;
#(
   parameter int unsigned WIDTH = DefWidth,
   parameter int unsigned DEPTH = DefDepth,
   localparam int unsigned AddrW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [AddrW-1:0] wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   input  logic [AddrW-1:0] rd_addr,
   output logic [WIDTH-1:0] rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] rd_data_q;

   // Storage array carries no reset; only the read register is cleared.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_data_q <= '0;
      end else if (rd_en) begin
         rd_data_q <= mem[rd_addr];
      end
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/class_fifo.sv
// Per-class FIFO: pointers, occupancy count, flags and sticky error around fifo_mem.
module class_fifo
   import class_fifo_pkg::*;
#(
   parameter int unsigned WIDTH = DefWidth,
   parameter int unsigned DEPTH = DefDepth,
   localparam int unsigned PtrW = $clog2(DEPTH),
   localparam int unsigned CntW = PtrW + 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            push,
   input  logic [WIDTH-1:0] data_in,
   input  logic            pop,
   input  logic [CntW-1:0] af_thr,
   input  logic [CntW-1:0] ae_thr,
   output logic [WIDTH-1:0] data_out,
   output logic            valid_out,
   output logic            full,
   output logic            empty,
   output logic            almost_full,
   output logic            almost_empty,
   output logic [CntW-1:0] count,
   output logic            error
);

   localparam logic [CntW-1:0] FullCount = CntW'(DEPTH);

   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0] count_q, count_d;
   logic            error_q, error_d;
   logic            valid_q;
   logic            push_ok, pop_ok;

   assign full         = (count_q == FullCount);
   assign empty        = (count_q == '0);
   assign almost_full  = (count_q >= af_thr);
   assign almost_empty = (count_q <= ae_thr);

   always_comb begin
      pop_ok   = pop & ~empty;
      // A simultaneous accepted pop frees a slot, so a full FIFO can still take the push.
      push_ok  = push & (~full | pop_ok);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      error_d  = error_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      if ((push & full & ~pop_ok) | (pop & empty)) error_d = 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         error_q  <= 1'b0;
         valid_q  <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         error_q  <= error_d;
         valid_q  <= pop_ok;
      end
   end

   fifo_mem #(
      .WIDTH(WIDTH),
      .DEPTH(DEPTH)
   ) u_mem (
      .clk    (clk),
      .reset  (reset),
      .wr_en  (push_ok),
      .wr_addr(wr_ptr_q),
      .wr_data(data_in),
      .rd_en  (pop_ok),
      .rd_addr(rd_ptr_q),
      .rd_data(data_out)
   );

   assign count     = count_q;
   assign error     = error_q;
   assign valid_out = valid_q;

endmodule

// File: tb/tb_class_fifo.sv
// Bench for class_fifo: table-driven flag vectors, scoreboard on popped data, corner sequences.
module tb_class_fifo;

   localparam int unsigned Depth = 8;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        push = 1'b0;
   logic        pop = 1'b0;
   logic [11:0] data_in = '0;
   logic [3:0]  af_thr = 4'd6;
   logic [3:0]  ae_thr = 4'd1;
   logic [11:0] data_out;
   logic        valid_out, full, empty, almost_full, almost_empty, error;
   logic [3:0]  count;

   int unsigned checks = 0;
   int unsigned errors = 0;

   logic [11:0] mdl_q[$];
   logic [11:0] sb_q[$];
   logic        m_err;
   logic [11:0] last_data;

   typedef struct {
      logic        push;
      logic        pop;
      logic [11:0] data;
      logic [3:0]  exp_count;
      logic        exp_empty;
      logic        exp_full;
      logic        exp_af;
      logic        exp_ae;
      logic        exp_err;
   } vec_t;

   vec_t vecs[15];

   class_fifo #(
      .WIDTH(12),
      .DEPTH(Depth)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .push        (push),
      .data_in     (data_in),
      .pop         (pop),
      .af_thr      (af_thr),
      .ae_thr      (ae_thr),
      .data_out    (data_out),
      .valid_out   (valid_out),
      .full        (full),
      .empty       (empty),
      .almost_full (almost_full),
      .almost_empty(almost_empty),
      .count       (count),
      .error       (error)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      mdl_q.delete();
      sb_q.delete();
      m_err     = 1'b0;
      last_data = '0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      model_clear();
   endtask

   // One clock of traffic; the model decides acceptance, the scoreboard holds words due out.
   task automatic step(input logic p, input logic q, input logic [11:0] d);
      logic m_full, m_empty, push_ok, pop_ok;
      logic [11:0] exp_d;
      push    = p;
      pop     = q;
      data_in = d;
      m_empty = (mdl_q.size() == 0);
      m_full  = (mdl_q.size() == Depth);
      pop_ok  = q && !m_empty;
      push_ok = p && (!m_full || pop_ok);
      if ((p && m_full && !pop_ok) || (q && m_empty)) m_err = 1'b1;
      if (pop_ok) sb_q.push_back(mdl_q.pop_front());
      if (push_ok) mdl_q.push_back(d);
      @(posedge clk);
      #1;
      push = 1'b0;
      pop  = 1'b0;
      chk("valid_out", 32'(valid_out), 32'(pop_ok));
      if (valid_out) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_pop_data", 32'(data_out), 32'hFFFF_FFFF);
         end else begin
            exp_d = sb_q.pop_front();
            chk("pop_data", 32'(data_out), 32'(exp_d));
            last_data = exp_d;
         end
      end else begin
         chk("data_hold", 32'(data_out), 32'(last_data));
      end
      chk("count", 32'(count), 32'(mdl_q.size()));
      chk("error", 32'(error), 32'(m_err));
      chk("full", 32'(full), 32'(mdl_q.size() == Depth));
      chk("empty", 32'(empty), 32'(mdl_q.size() == 0));
      chk("almost_full", 32'(almost_full), 32'(32'(mdl_q.size()) >= 32'(af_thr)));
      chk("almost_empty", 32'(almost_empty), 32'(32'(mdl_q.size()) <= 32'(ae_thr)));
   endtask

   initial begin
      vecs[0] = '{1'b1, 1'b0, 12'h401, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[1] = '{1'b1, 1'b0, 12'h402, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[2] = '{1'b1, 1'b0, 12'h403, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[3] = '{1'b0, 1'b1, 12'h000, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[4] = '{1'b0, 1'b1, 12'h000, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[5] = '{1'b0, 1'b1, 12'h000, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[6]  = '{1'b1, 1'b0, 12'h800, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[7]  = '{1'b1, 1'b0, 12'h801, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[8]  = '{1'b1, 1'b0, 12'h802, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[9]  = '{1'b1, 1'b0, 12'h803, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[10] = '{1'b1, 1'b0, 12'h804, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[11] = '{1'b1, 1'b0, 12'h805, 4'd6, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[12] = '{1'b1, 1'b0, 12'h806, 4'd7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[13] = '{1'b1, 1'b0, 12'h807, 4'd8, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[14] = '{1'b1, 1'b0, 12'h808, 4'd8, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

      do_reset();
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_almost_empty", 32'(almost_empty), 32'd1);
      chk("rst_error", 32'(error), 32'd0);
      chk("rst_valid", 32'(valid_out), 32'd0);
      chk("rst_data_out", 32'(data_out), 32'd0);

      // Basic order, threshold flags, fill to full and overflow drop.
      for (int i = 0; i < 15; i++) begin
         step(vecs[i].push, vecs[i].pop, vecs[i].data);
         chk($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].exp_count));
         chk($sformatf("vec%0d_empty", i), 32'(empty), 32'(vecs[i].exp_empty));
         chk($sformatf("vec%0d_full", i), 32'(full), 32'(vecs[i].exp_full));
         chk($sformatf("vec%0d_af", i), 32'(almost_full), 32'(vecs[i].exp_af));
         chk($sformatf("vec%0d_ae", i), 32'(almost_empty), 32'(vecs[i].exp_ae));
         chk($sformatf("vec%0d_err", i), 32'(error), 32'(vecs[i].exp_err));
      end

      // Threshold change is seen on the flag without a clock edge.
      af_thr = 4'd9;
      #1;
      chk("af_thr_comb_off", 32'(almost_full), 32'd0);
      af_thr = 4'd8;
      #1;
      chk("af_thr_comb_on", 32'(almost_full), 32'd1);
      af_thr = 4'd6;

      // Drain: 0x800..0x807 in order, 0x808 never stored, error stays sticky.
      for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 12'h000);
      chk("drain_last", 32'(data_out), 32'h807);
      chk("drain_err_sticky", 32'(error), 32'd1);
      step(1'b0, 1'b0, 12'h000);

      // Push and pop together while full.
      do_reset();
      for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 12'h900 + 12'(i));
      step(1'b1, 1'b1, 12'hC0A);
      chk("fullpp_count", 32'(count), 32'd8);
      chk("fullpp_err", 32'(error), 32'd0);
      chk("fullpp_data", 32'(data_out), 32'h900);
      for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 12'h000);
      chk("fullpp_c0a_last", 32'(data_out), 32'hC0A);
      chk("fullpp_empty", 32'(empty), 32'd1);

      // Push and pop together while empty: pop rejected, push taken.
      step(1'b1, 1'b1, 12'h005);
      chk("emptypp_err", 32'(error), 32'd1);
      chk("emptypp_valid", 32'(valid_out), 32'd0);
      chk("emptypp_count", 32'(count), 32'd1);
      step(1'b0, 1'b1, 12'h000);
      chk("emptypp_data", 32'(data_out), 32'h005);

      // Asynchronous reset mid-cycle discards contents.
      do_reset();
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 12'hA00 + 12'(i));
      step(1'b0, 1'b1, 12'h000);
      #2;
      reset = 1'b1;
      #1;
      chk("arst_count", 32'(count), 32'd0);
      chk("arst_empty", 32'(empty), 32'd1);
      chk("arst_data_out", 32'(data_out), 32'd0);
      chk("arst_valid", 32'(valid_out), 32'd0);
      chk("arst_err", 32'(error), 32'd0);
      #1;
      reset = 1'b0;
      model_clear();
      step(1'b0, 1'b1, 12'h000);
      chk("arst_underflow", 32'(error), 32'd1);
      step(1'b1, 1'b0, 12'h3C7);
      step(1'b0, 1'b1, 12'h000);
      chk("arst_fresh_data", 32'(data_out), 32'h3C7);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
